// File: rtl/int_div_int_to_fixed_point.sv
// Sequential signed int / int -> fixed point (X integer part, Y = fraction x 1e5) with start/done handshake.
// Optional build macro ROUND_EN: round the fraction to nearest instead of truncating toward zero.
module int_div_int_to_fixed_point #(
    parameter int N_W        = 21,
    parameter int FRAC_SCALE = 100000,
    parameter int FRAC_ITER  = 17,
    parameter int SAT_INT    = 255
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic [N_W-1:0] numer,
    input  logic [N_W-1:0] denom,
    output logic           busy,
    output logic           done,
    output logic [9:0]     fixed_X,
    output logic [17:0]    fixed_Y,
    output logic           overflow,
    output logic           div_zero
);

    localparam int P_W = N_W + FRAC_ITER;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INT  = 2'd1;
    localparam logic [1:0] S_FRAC = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]           state_r;
    logic [4:0]           cnt_r;
    logic [N_W-1:0]       num_sh_r;
    logic [N_W-1:0]       den_r;
    logic [N_W-1:0]       rem_r;
    logic [N_W-1:0]       qi_r;
    logic [FRAC_ITER-1:0] qf_r;
    logic                 neg_r;
    logic                 dz_r;

    logic [N_W-1:0]       abs_n_s;
    logic [N_W-1:0]       abs_d_s;
    logic [N_W:0]         trial_s;
    logic                 ge_s;
    logic [N_W-1:0]       rem_nx_s;
    logic [P_W-1:0]       prod_s;
    logic [N_W-1:0]       qi_f_s;
    logic [FRAC_ITER-1:0] qf_f_s;
    logic [9:0]           res_x_s;
    logic [17:0]          res_y_s;
    logic                 res_ov_s;
    logic                 res_dz_s;

    // Operand magnitudes and one restoring-division step shared by the INT and FRAC phases.
    always_comb begin
        abs_n_s  = numer[N_W-1] ? (N_W'(0) - numer) : numer;
        abs_d_s  = denom[N_W-1] ? (N_W'(0) - denom) : denom;
        trial_s  = {rem_r, num_sh_r[N_W-1]};
        ge_s     = (trial_s >= {1'b0, den_r});
        rem_nx_s = ge_s ? N_W'(trial_s - {1'b0, den_r}) : N_W'(trial_s);
        // rem*FRAC_SCALE < den*2^FRAC_ITER, so its top N_W bits already form a valid partial remainder.
        prod_s   = P_W'(rem_nx_s) * P_W'(FRAC_SCALE);
    end

    // Optional round-to-nearest of the fractional quotient, carrying into the integer part.
    always_comb begin
        qi_f_s = qi_r;
        qf_f_s = qf_r;
`ifdef ROUND_EN
        if ({rem_r, 1'b0} >= {1'b0, den_r}) begin
            if ((qf_r + FRAC_ITER'(1)) == FRAC_ITER'(FRAC_SCALE)) begin
                qf_f_s = FRAC_ITER'(0);
                qi_f_s = qi_r + N_W'(1);
            end else begin
                qf_f_s = qf_r + FRAC_ITER'(1);
                qi_f_s = qi_r;
            end
        end else begin
            qf_f_s = qf_r;
            qi_f_s = qi_r;
        end
`else
        qi_f_s = qi_r;
        qf_f_s = qf_r;
`endif
    end

    // Sign, saturation and division-by-zero mapping into the codebase (X, Y) encoding.
    always_comb begin
        res_ov_s = 1'b0;
        res_dz_s = 1'b0;
        res_x_s  = 10'd0;
        res_y_s  = {1'b0, qf_f_s};
        if (dz_r) begin
            res_dz_s = 1'b1;
            res_x_s  = 10'(SAT_INT);
            res_y_s  = 18'(FRAC_SCALE - 1);
        end else if (qi_f_s > N_W'(SAT_INT)) begin
            res_ov_s = 1'b1;
            res_x_s  = neg_r ? (10'd0 - 10'(SAT_INT)) : 10'(SAT_INT);
            res_y_s  = 18'(FRAC_SCALE - 1);
        end else if ((qi_f_s == N_W'(0)) && (qf_f_s == FRAC_ITER'(0))) begin
            res_x_s  = 10'd0;
            res_y_s  = 18'd0;
        end else if (neg_r && (qi_f_s == N_W'(0))) begin
            // 256 marks a negative value with zero integer part.
            res_x_s  = 10'd256;
        end else if (neg_r) begin
            res_x_s  = 10'd0 - qi_f_s[9:0];
        end else begin
            res_x_s  = qi_f_s[9:0];
        end
    end

    // Control FSM, division datapath and registered result outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            cnt_r    <= 5'd0;
            num_sh_r <= '0;
            den_r    <= '0;
            rem_r    <= '0;
            qi_r     <= '0;
            qf_r     <= '0;
            neg_r    <= 1'b0;
            dz_r     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fixed_X  <= 10'd0;
            fixed_Y  <= 18'd0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        num_sh_r <= abs_n_s;
                        den_r    <= abs_d_s;
                        rem_r    <= '0;
                        qi_r     <= '0;
                        qf_r     <= '0;
                        neg_r    <= numer[N_W-1] ^ denom[N_W-1];
                        dz_r     <= (denom == N_W'(0));
                        cnt_r    <= 5'd0;
                        busy     <= 1'b1;
                        state_r  <= S_INT;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end
                S_INT: begin
                    qi_r <= {qi_r[N_W-2:0], ge_s};
                    if (cnt_r == 5'(N_W - 1)) begin
                        rem_r    <= prod_s[P_W-1:FRAC_ITER];
                        num_sh_r <= {prod_s[FRAC_ITER-1:0], {(N_W-FRAC_ITER){1'b0}}};
                        cnt_r    <= 5'd0;
                        state_r  <= S_FRAC;
                    end else begin
                        rem_r    <= rem_nx_s;
                        num_sh_r <= {num_sh_r[N_W-2:0], 1'b0};
                        cnt_r    <= cnt_r + 5'd1;
                    end
                end
                S_FRAC: begin
                    qf_r     <= {qf_r[FRAC_ITER-2:0], ge_s};
                    rem_r    <= rem_nx_s;
                    num_sh_r <= {num_sh_r[N_W-2:0], 1'b0};
                    if (cnt_r == 5'(FRAC_ITER - 1)) begin
                        cnt_r   <= 5'd0;
                        state_r <= S_FIN;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end
                S_FIN: begin
                    fixed_X  <= res_x_s;
                    fixed_Y  <= res_y_s;
                    overflow <= res_ov_s;
                    div_zero <= res_dz_s;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_int_to_fixed_point.sv
// Self-checking bench for int_div_int_to_fixed_point: directed corner cases, random operands
// against an arithmetic reference, handshake, abort and back-to-back behaviour.
module tb_int_div_int_to_fixed_point;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [20:0] numer;
    logic [20:0] denom;
    logic        busy;
    logic        done;
    logic [9:0]  fixed_X;
    logic [17:0] fixed_Y;
    logic        overflow;
    logic        div_zero;

    int n_checks;
    int n_fail;

    int_div_int_to_fixed_point dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .numer    (numer),
        .denom    (denom),
        .busy     (busy),
        .done     (done),
        .fixed_X  (fixed_X),
        .fixed_Y  (fixed_Y),
        .overflow (overflow),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the value, then mapped to the (X, Y) encoding.
    function automatic void model(input int n, input int d, output logic [9:0] x,
                                  output logic [17:0] y, output logic ov, output logic dzo);
        longint an, ad, qi, r, qf, r2;
        bit neg;
        ov  = 1'b0;
        dzo = 1'b0;
        x   = 10'd0;
        y   = 18'd0;
        if (d == 0) begin
            x   = 10'd255;
            y   = 18'd99999;
            dzo = 1'b1;
            return;
        end
        an  = (n < 0) ? -longint'(n) : longint'(n);
        ad  = (d < 0) ? -longint'(d) : longint'(d);
        neg = (n < 0) != (d < 0);
        qi  = an / ad;
        r   = an % ad;
        qf  = (r * 100000) / ad;
        r2  = (r * 100000) % ad;
`ifdef ROUND_EN
        if (2 * r2 >= ad) qf = qf + 1;
        if (qf == 100000) begin
            qf = 0;
            qi = qi + 1;
        end
`endif
        if (qi > 255) begin
            ov = 1'b1;
            y  = 18'd99999;
            x  = neg ? 10'(-255) : 10'd255;
        end else if (qi == 0 && qf == 0) begin
            x = 10'd0;
            y = 18'd0;
        end else if (neg && qi == 0) begin
            x = 10'd256;
            y = 18'(qf);
        end else begin
            x = neg ? 10'(-qi) : 10'(qi);
            y = 18'(qf);
        end
    endfunction

    task automatic chk_result(input string tag, input int n, input int d);
        logic [9:0]  ex;
        logic [17:0] ey;
        logic        eov, edz;
        model(n, d, ex, ey, eov, edz);
        chk({tag, ".X"}, 32'(fixed_X), 32'(ex));
        chk({tag, ".Y"}, 32'(fixed_Y), 32'(ey));
        chk({tag, ".ov"}, 32'(overflow), 32'(eov));
        chk({tag, ".dz"}, 32'(div_zero), 32'(edz));
    endtask

    // Drives start in the current cycle, then waits (bounded) for done and checks latency and result.
    task automatic launch(input string tag, input int n, input int d);
        int lat;
        bit seen;
        start = 1'b1;
        numer = n[20:0];
        denom = d[20:0];
        @(posedge clock); #1;
        start = 1'b0;
        numer = 21'h0AAAA;
        denom = 21'h15555;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clock); #1;
            if (done) begin
                lat  = i;
                seen = 1'b1;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'd39);
        chk_result(tag, n, d);
    endtask

    initial begin
        int n, d, r, cnt_done, lat;
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        numer    = 21'd0;
        denom    = 21'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.X", 32'(fixed_X), 32'd0);
        chk("rst.Y", 32'(fixed_Y), 32'd0);
        chk("rst.ov", 32'(overflow), 32'd0);
        chk("rst.dz", 32'(div_zero), 32'd0);
        resetn = 1'b1;

        @(negedge clock); launch("d1_3", 1, 3);
        @(negedge clock); launch("d2_3", 2, 3);
        @(negedge clock); launch("dm7_2", -7, 2);
        @(negedge clock); launch("d7_m2", 7, -2);
        @(negedge clock); launch("dm1_4", -1, 4);
        @(negedge clock); launch("d0_m5", 0, -5);
        @(negedge clock); launch("d1000_3", 1000, 3);
        @(negedge clock); launch("dm1000_3", -1000, 3);
        @(negedge clock); launch("dm9_0", -9, 0);
        @(negedge clock); launch("dmin_1", -1048576, 1);
        @(negedge clock); launch("d5_5", 5, 5);
        @(negedge clock); launch("d255_1", -255, -1);
        @(negedge clock); launch("dbig_mmin", 1048575, -1048576);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 2))
                0:       r = 20;
                1:       r = 2000;
                default: r = 1048575;
            endcase
            n = int'($urandom_range(0, 2 * r)) - r;
            d = int'($urandom_range(0, 2 * r)) - r;
            if (k % 3 == 0) d = int'($urandom_range(0, 40)) - 20;
            @(negedge clock); launch("rnd", n, d);
        end

        // A second start while busy must be ignored.
        @(negedge clock);
        start = 1'b1; numer = 21'd1; denom = 21'd3;
        @(posedge clock); #1;
        start = 1'b0;
        cnt_done = 0;
        lat = 0;
        for (int i = 1; i <= 90; i++) begin
            if (i == 10) begin
                start = 1'b1; numer = 21'd5; denom = 21'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            if (done) begin
                cnt_done++;
                if (lat == 0) lat = i;
            end
        end
        chk("ign.ndone", 32'(cnt_done), 32'd1);
        chk("ign.lat", 32'(lat), 32'd39);
        chk_result("ign", 1, 3);

        // Mid-operation reset aborts without a done.
        @(negedge clock); launch("pre", 7, 2);
        @(negedge clock);
        start = 1'b1; numer = 21'd1; denom = 21'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.X", 32'(fixed_X), 32'd0);
        chk("abort.Y", 32'(fixed_Y), 32'd0);
        chk("abort.ov", 32'(overflow), 32'd0);
        chk("abort.dz", 32'(div_zero), 32'd0);
        resetn = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clock); #1;
            if (done) cnt_done++;
        end
        chk("abort.ndone", 32'(cnt_done), 32'd0);

        // Back-to-back: the second start is issued in the done cycle of the first.
        @(negedge clock); launch("b2b1", 2, 3);
        chk("b2b1.done", 32'(done), 32'd1);
        launch("b2b2", -1000, 7);
        @(posedge clock); #1;
        chk("b2b2.pulse", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
